// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: funct3 codes, FSM states
// and the alignment / byte-enable helpers used by the lane-steering logic.
package dmem_pkg;

   // RV32I load/store size and sign encodings (funct3)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   // True when the access is misaligned for its size, or funct3 is not a legal code
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      case (f3)
         F3_B, F3_BU: bad = 1'b0;
         F3_H, F3_HU: bad = off[0];
         F3_W:        bad = (off != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte lanes touched by an access of size f3 at byte offset off
   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3)
         F3_B, F3_BU: be = 4'b0001 << off;
         F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
         F3_W:        be = 4'b1111;
         default:     be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for sub-word accesses: extracts and extends load data from the
// addressed word, and replicates store data across lanes with a byte enable.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_rword,
   input  logic [31:0] i_wd,
   output logic [31:0] o_load,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_be,
   output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte/half and extend it according to funct3
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it
      // unassigned; a missing default here would infer a latch.
      w_byte = i_rword[7:0];
      case (i_offset)
         2'd1:    w_byte = i_rword[15:8];
         2'd2:    w_byte = i_rword[23:16];
         2'd3:    w_byte = i_rword[31:24];
         default: w_byte = i_rword[7:0];
      endcase
      w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
      o_load = '0;
      case (i_funct3)
         F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load = {24'd0, w_byte};
         F3_H:    o_load = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load = {16'd0, w_half};
         F3_W:    o_load = i_rword;
         default: o_load = '0;
      endcase
   end

   // Replicate store data so every selected lane sees the right bits
   always_comb begin
      o_wdata = i_wd;
      case (i_funct3)
         F3_B, F3_BU: o_wdata = {4{i_wd[7:0]}};
         F3_H, F3_HU: o_wdata = {2{i_wd[15:0]}};
         default:     o_wdata = i_wd;
      endcase
   end

   assign o_be       = byte_en(i_funct3, i_offset);
   assign o_misalign = is_misaligned(i_funct3, i_offset);

endmodule

// File: rtl/dmem_bytelane.sv
// RV32I data memory with sub-word load/store, misalignment and out-of-range
// detection, a sticky store-error flag and a post-reset initialisation sweep.
// Reads are combinational; writes land on the rising edge.
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_W      = 32,
   parameter int INIT_ZERO   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              WE,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] A,
   input  logic [31:0]       WD,
   output logic [31:0]       RD,
   output logic              ready,
   output logic              misalign,
   output logic              oob,
   input  logic              err_clr,
   output logic              err_sticky
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_cnt;
   logic               r_err;
   logic [31:0]        r_mem [DEPTH_WORDS];

   logic [IDX_W-1:0]   w_idx;
   logic               w_oob;
   logic               w_misalign;
   logic               w_bad;
   logic               w_run;
   logic               w_store;
   logic [31:0]        w_rword;
   logic [31:0]        w_load;
   logic [31:0]        w_wdata;
   logic [3:0]         w_be;
   logic [31:0]        w_init_word;

   // Depth is a power of two, so any set bit above the index field is out of
   // range; testing the whole upper field means high address bits never alias.
   assign w_idx   = A[IDX_W+1:2];
   assign w_oob   = |A[ADDR_W-1:IDX_W+2];
   assign w_rword = r_mem[w_idx];
   assign w_bad   = w_misalign | w_oob;
   assign w_run   = (r_state == S_RUN);
   assign w_store = w_run & WE & ~w_bad;

   assign w_init_word = (INIT_ZERO != 0) ? 32'd0 : 32'(r_cnt);

   dmem_lane_align u_lane_align (
      .i_funct3   (funct3),
      .i_offset   (A[1:0]),
      .i_rword    (w_rword),
      .i_wd       (WD),
      .o_load     (w_load),
      .o_wdata    (w_wdata),
      .o_be       (w_be),
      .o_misalign (w_misalign)
   );

   // Next-state logic: the sweep ends on the edge that writes the last word
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  if (r_cnt == IDX_W'(DEPTH_WORDS - 1)) w_state_nxt = S_RUN;
         S_RUN:   w_state_nxt = S_RUN;
         default: w_state_nxt = S_INIT;
      endcase
   end

   // State register and sweep counter
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of statement order.
      if (reset) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
      end
   end

   // Sticky store-error flag; a new error wins over a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_run) begin
         if (WE && w_bad)  r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end

   // Memory array: init sweep in INIT, byte-lane stores in RUN
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch; the INIT sweep rewrites every word
      // after reset, and a reset on the array would prevent RAM inference.
      if (r_state == S_INIT) begin
         r_mem[r_cnt] <= w_init_word;
      end else if (w_store) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   assign RD         = (w_run && !w_bad) ? w_load : 32'd0;
   assign ready      = w_run;
   assign misalign   = w_misalign;
   assign oob        = w_oob;
   assign err_sticky = r_err;

endmodule
